fifo_ptr_gen_grey: RTL and testbench

FIFO_PTR_GEN_GREY -- requirements
Module: fifo_ptr_gen_grey

---
 rtl/fifo_ptr_gen_grey.sv | 93 +++++++++
 tb/tb_fifo_ptr_gen_grey.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fifo_ptr_gen_grey.sv
// One side of an asynchronous FIFO: binary/Gray pointer pair plus the FULL/EMPTY flag
// and free-space/available level derived from the opposite side's synchronised Gray pointer.
module fifo_ptr_gen_grey #(
    parameter int ADDR_WIDTH = 4,
    parameter int MAX_INCR   = 1,
    parameter bit IS_WRITE   = 1'b1,
    localparam int PW        = ADDR_WIDTH + 1,
    localparam int CW        = $clog2(MAX_INCR + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CLR,
    input  logic          INCR,
    input  logic [CW-1:0] INCR_CNT,
    input  logic [PW-1:0] REMOTE_GREY,
    output logic [PW-1:0] PTR_BIN,
    output logic [PW-1:0] PTR_GREY,
    output logic [PW-1:0] PTR_GREY_NXT,
    output logic [ADDR_WIDTH-1:0] ADDR_BIN,
    output logic          FLAG,
    output logic [PW-1:0] LEVEL,
    output logic          ERR
);

    localparam logic [PW-1:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [CW-1:0] MAX_W   = CW'(MAX_INCR);

    logic [PW-1:0] ptr_bin_q, ptr_bin_d;
    logic [PW-1:0] ptr_grey_q, ptr_grey_d;
    logic          err_q, err_d;
    logic [PW-1:0] remote_bin;
    logic [PW-1:0] occ;
    logic [PW-1:0] level;
    logic          flag;
    logic          accept;

    function automatic logic [PW-1:0] grey_to_bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    always_comb begin
        remote_bin = grey_to_bin(REMOTE_GREY);
        occ        = ptr_bin_q - remote_bin;
        if (IS_WRITE) begin
            level = DEPTH_W - occ;
            flag  = (occ == DEPTH_W);
        end else begin
            level = remote_bin - ptr_bin_q;
            flag  = (level == '0);
        end
    end

    // INCR is a request without a ready: it is taken in the cycle it is high, and a
    // refusal is reported only by ERR pulsing in the following cycle.
    always_comb begin
        accept    = INCR && !CLR && (INCR_CNT <= MAX_W) && (PW'(INCR_CNT) <= level);
        ptr_bin_d = ptr_bin_q;
        err_d     = INCR && !CLR && !accept;
        if (RST || CLR) begin
            ptr_bin_d = '0;
            err_d     = 1'b0;
        end else if (accept) begin
            ptr_bin_d = ptr_bin_q + PW'(INCR_CNT);
        end
        ptr_grey_d = ptr_bin_d ^ (ptr_bin_d >> 1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_bin_q  <= '0;
            ptr_grey_q <= '0;
            err_q      <= 1'b0;
        end else begin
            ptr_bin_q  <= ptr_bin_d;
            ptr_grey_q <= ptr_grey_d;
            err_q      <= err_d;
        end
    end

    assign PTR_BIN      = ptr_bin_q;
    assign PTR_GREY     = ptr_grey_q;
    assign PTR_GREY_NXT = ptr_grey_d;
    assign ADDR_BIN     = ptr_bin_q[ADDR_WIDTH-1:0];
    assign FLAG         = flag;
    assign LEVEL        = level;
    assign ERR          = err_q;

endmodule

// File: tb/tb_fifo_ptr_gen_grey.sv
// Directed bench for a write-side and a read-side pointer generator (ADDR_WIDTH=2, MAX_INCR=2).
module tb_fifo_ptr_gen_grey;

    typedef struct packed {
        logic        side;   // 1 = write-side instance
        logic [2:0]  bin;
        logic [2:0]  grey;
        logic [2:0]  nxt;
        logic        flag;
        logic [2:0]  level;
        logic        err;
        logic [15:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   tag_cnt  = 0;

    logic       clk = 1'b0;
    logic       rst_w, clr_w, incr_w, rst_r, clr_r, incr_r;
    logic [1:0] cnt_w, cnt_r;
    logic [2:0] remote_w, remote_r;
    logic [2:0] bin_w, grey_w, nxt_w, level_w, bin_r, grey_r, nxt_r, level_r;
    logic [1:0] addr_w, addr_r;
    logic       flag_w, err_w, flag_r, err_r;

    always #5 clk = ~clk;

    fifo_ptr_gen_grey #(.ADDR_WIDTH(2), .MAX_INCR(2), .IS_WRITE(1'b1)) u_wr (
        .CLK(clk), .RST(rst_w), .CLR(clr_w), .INCR(incr_w), .INCR_CNT(cnt_w),
        .REMOTE_GREY(remote_w), .PTR_BIN(bin_w), .PTR_GREY(grey_w),
        .PTR_GREY_NXT(nxt_w), .ADDR_BIN(addr_w), .FLAG(flag_w), .LEVEL(level_w),
        .ERR(err_w)
    );

    fifo_ptr_gen_grey #(.ADDR_WIDTH(2), .MAX_INCR(2), .IS_WRITE(1'b0)) u_rd (
        .CLK(clk), .RST(rst_r), .CLR(clr_r), .INCR(incr_r), .INCR_CNT(cnt_r),
        .REMOTE_GREY(remote_r), .PTR_BIN(bin_r), .PTR_GREY(grey_r),
        .PTR_GREY_NXT(nxt_r), .ADDR_BIN(addr_r), .FLAG(flag_r), .LEVEL(level_r),
        .ERR(err_r)
    );

    task automatic chk(input string name, input int tag, input logic [2:0] act,
                       input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %b expected %b", name, tag, act, exp);
        end
    endtask

    // Monitor: every cycle with a pending expectation, compare the outputs mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.side) begin
                chk("w_ptr_bin", int'(e.tag), bin_w, e.bin);
                chk("w_ptr_grey", int'(e.tag), grey_w, e.grey);
                chk("w_grey_nxt", int'(e.tag), nxt_w, e.nxt);
                chk("w_addr_bin", int'(e.tag), {1'b0, addr_w}, {1'b0, e.bin[1:0]});
                chk("w_flag", int'(e.tag), {2'b0, flag_w}, {2'b0, e.flag});
                chk("w_level", int'(e.tag), level_w, e.level);
                chk("w_err", int'(e.tag), {2'b0, err_w}, {2'b0, e.err});
            end else begin
                chk("r_ptr_bin", int'(e.tag), bin_r, e.bin);
                chk("r_ptr_grey", int'(e.tag), grey_r, e.grey);
                chk("r_grey_nxt", int'(e.tag), nxt_r, e.nxt);
                chk("r_addr_bin", int'(e.tag), {1'b0, addr_r}, {1'b0, e.bin[1:0]});
                chk("r_flag", int'(e.tag), {2'b0, flag_r}, {2'b0, e.flag});
                chk("r_level", int'(e.tag), level_r, e.level);
                chk("r_err", int'(e.tag), {2'b0, err_r}, {2'b0, e.err});
            end
        end
    end

    // Drive one cycle of inputs on one instance and queue the outputs expected this cycle.
    task automatic step(input logic side, input logic rst, input logic clr, input logic incr,
                        input logic [1:0] cnt, input logic [2:0] remote,
                        input logic [2:0] e_bin, input logic [2:0] e_grey,
                        input logic [2:0] e_nxt, input logic e_flag,
                        input logic [2:0] e_level, input logic e_err);
        exp_t e;
        if (side) begin
            rst_w = rst; clr_w = clr; incr_w = incr; cnt_w = cnt; remote_w = remote;
        end else begin
            rst_r = rst; clr_r = clr; incr_r = incr; cnt_r = cnt; remote_r = remote;
        end
        e.side = side; e.bin = e_bin; e.grey = e_grey; e.nxt = e_nxt;
        e.flag = e_flag; e.level = e_level; e.err = e_err; e.tag = 16'(tag_cnt);
        tag_cnt++;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_w = 1'b1; clr_w = 1'b0; incr_w = 1'b0; cnt_w = 2'd0; remote_w = 3'b000;
        rst_r = 1'b1; clr_r = 1'b0; incr_r = 1'b0; cnt_r = 2'd0; remote_r = 3'b000;
        @(posedge clk);
        #1;
        rst_w = 1'b0;
        rst_r = 1'b0;

        //   side rst clr inc cnt remote  bin   grey   nxt   flg level err
        // Reset state, then fill to full and overflow
        step(1, 0, 0, 0, 2'd0, 3'b000, 3'd0, 3'b000, 3'b000, 0, 3'd4, 0);
        step(1, 0, 0, 1, 2'd1, 3'b000, 3'd0, 3'b000, 3'b001, 0, 3'd4, 0);
        step(1, 0, 0, 1, 2'd1, 3'b000, 3'd1, 3'b001, 3'b011, 0, 3'd3, 0);
        step(1, 0, 0, 1, 2'd1, 3'b000, 3'd2, 3'b011, 3'b010, 0, 3'd2, 0);
        step(1, 0, 0, 1, 2'd1, 3'b000, 3'd3, 3'b010, 3'b110, 0, 3'd1, 0);
        step(1, 0, 0, 1, 2'd1, 3'b000, 3'd4, 3'b110, 3'b110, 1, 3'd0, 0);
        step(1, 0, 0, 0, 2'd0, 3'b000, 3'd4, 3'b110, 3'b110, 1, 3'd0, 1);
        step(1, 0, 0, 0, 2'd0, 3'b000, 3'd4, 3'b110, 3'b110, 1, 3'd0, 0);
        // Wrap with remote at 4
        step(1, 0, 0, 1, 2'd1, 3'b110, 3'd4, 3'b110, 3'b111, 0, 3'd4, 0);
        step(1, 0, 0, 1, 2'd1, 3'b110, 3'd5, 3'b111, 3'b101, 0, 3'd3, 0);
        step(1, 0, 0, 1, 2'd1, 3'b110, 3'd6, 3'b101, 3'b100, 0, 3'd2, 0);
        step(1, 0, 0, 1, 2'd1, 3'b110, 3'd7, 3'b100, 3'b000, 0, 3'd1, 0);
        step(1, 0, 0, 0, 2'd0, 3'b110, 3'd0, 3'b000, 3'b000, 1, 3'd0, 0);
        // Multi-increment: LEVEL=1 rejects CNT=2, LEVEL=2 accepts it
        step(1, 0, 0, 1, 2'd2, 3'b111, 3'd0, 3'b000, 3'b000, 0, 3'd1, 0);
        step(1, 0, 0, 0, 2'd0, 3'b111, 3'd0, 3'b000, 3'b000, 0, 3'd1, 1);
        step(1, 0, 0, 1, 2'd2, 3'b101, 3'd0, 3'b000, 3'b011, 0, 3'd2, 0);
        step(1, 0, 0, 0, 2'd0, 3'b101, 3'd2, 3'b011, 3'b011, 1, 3'd0, 0);
        // Clear wins over an increment at PTR_BIN=3
        step(1, 0, 0, 1, 2'd1, 3'b011, 3'd2, 3'b011, 3'b010, 0, 3'd4, 0);
        step(1, 0, 1, 1, 2'd1, 3'b011, 3'd3, 3'b010, 3'b000, 0, 3'd3, 0);
        step(1, 0, 0, 0, 2'd0, 3'b000, 3'd0, 3'b000, 3'b000, 0, 3'd4, 0);
        // Reset mid-stream at PTR_BIN=5
        step(1, 0, 0, 1, 2'd2, 3'b000, 3'd0, 3'b000, 3'b011, 0, 3'd4, 0);
        step(1, 0, 0, 1, 2'd2, 3'b000, 3'd2, 3'b011, 3'b110, 0, 3'd2, 0);
        step(1, 0, 0, 1, 2'd1, 3'b110, 3'd4, 3'b110, 3'b111, 0, 3'd4, 0);
        step(1, 1, 0, 1, 2'd1, 3'b110, 3'd5, 3'b111, 3'b000, 0, 3'd3, 0);
        step(1, 0, 0, 0, 2'd0, 3'b000, 3'd0, 3'b000, 3'b000, 0, 3'd4, 0);
        // CNT=0 is a silent no-op; CNT=3 exceeds MAX_INCR and is refused
        step(1, 0, 0, 1, 2'd0, 3'b000, 3'd0, 3'b000, 3'b000, 0, 3'd4, 0);
        step(1, 0, 0, 0, 2'd0, 3'b000, 3'd0, 3'b000, 3'b000, 0, 3'd4, 0);
        step(1, 0, 0, 1, 2'd3, 3'b000, 3'd0, 3'b000, 3'b000, 0, 3'd4, 0);
        step(1, 0, 0, 0, 2'd0, 3'b000, 3'd0, 3'b000, 3'b000, 0, 3'd4, 1);
        step(1, 0, 0, 0, 2'd0, 3'b000, 3'd0, 3'b000, 3'b000, 0, 3'd4, 0);

        // Read side: empty after reset, drain two words, underflow
        step(0, 0, 0, 0, 2'd0, 3'b000, 3'd0, 3'b000, 3'b000, 1, 3'd0, 0);
        step(0, 0, 0, 0, 2'd0, 3'b011, 3'd0, 3'b000, 3'b000, 0, 3'd2, 0);
        step(0, 0, 0, 1, 2'd1, 3'b011, 3'd0, 3'b000, 3'b001, 0, 3'd2, 0);
        step(0, 0, 0, 1, 2'd1, 3'b011, 3'd1, 3'b001, 3'b011, 0, 3'd1, 0);
        step(0, 0, 0, 1, 2'd1, 3'b011, 3'd2, 3'b011, 3'b011, 1, 3'd0, 0);
        step(0, 0, 0, 0, 2'd0, 3'b011, 3'd2, 3'b011, 3'b011, 1, 3'd0, 1);
        step(0, 0, 0, 0, 2'd0, 3'b011, 3'd2, 3'b011, 3'b011, 1, 3'd0, 0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
